// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS stopwatch with STOP / RUN / ADJ modes.
// The only timebase is the tick_run (1 Hz) and tick_adj (5 Hz) enables.
// Optional feature macro: STOPWATCH_BLINK_EN. When it is defined, the
// selected field blanks to 4'hF on alternate tick_run periods while in ADJ.
module stopwatch_core #(
  parameter int unsigned MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_run,
  input  logic       tick_adj,
  input  logic       pause_btn,
  input  logic       clear_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_ONES_LIM = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    ADJ  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_n, mo_n, st_n, so_n;
  logic       wrap_n;

  // incremented seconds / minutes candidates
  logic [3:0] sec_tens_inc, sec_ones_inc;
  logic       sec_carry;
  logic [3:0] min_tens_inc, min_ones_inc;
  logic       min_roll;

  // seconds +1 with 59 -> 00 rollover
  always_comb begin
    sec_tens_inc = st_q;
    sec_ones_inc = so_q + 4'd1;
    sec_carry    = 1'b0;
    if (so_q >= 4'd9) begin
      sec_ones_inc = '0;
      if (st_q >= 4'd5) begin
        sec_tens_inc = '0;
        sec_carry    = 1'b1;
      end else begin
        sec_tens_inc = st_q + 4'd1;
      end
    end
  end

  // minutes +1 with MIN_LIMIT -> 00 rollover
  always_comb begin
    min_tens_inc = mt_q;
    min_ones_inc = mo_q + 4'd1;
    min_roll     = 1'b0;
    if (mt_q == MIN_TENS_LIM && mo_q == MIN_ONES_LIM) begin
      min_tens_inc = '0;
      min_ones_inc = '0;
      min_roll     = 1'b1;
    end else if (mo_q >= 4'd9) begin
      min_ones_inc = '0;
      min_tens_inc = (mt_q >= 4'd9) ? 4'd0 : mt_q + 4'd1;
    end
  end

  // next state and next digit values; clear > adj change > pause > tick
  always_comb begin
    state_n = state;
    mt_n    = mt_q;
    mo_n    = mo_q;
    st_n    = st_q;
    so_n    = so_q;
    wrap_n  = 1'b0;
    if (clear_btn) begin
      state_n = adj ? ADJ : STOP;
      mt_n    = '0;
      mo_n    = '0;
      st_n    = '0;
      so_n    = '0;
    end else if (state != ADJ && adj) begin
      state_n = ADJ;
    end else if (state == ADJ && !adj) begin
      state_n = STOP;
    end else begin
      unique case (state)
        STOP: begin
          if (pause_btn) state_n = RUN;
        end
        RUN: begin
          if (pause_btn) begin
            state_n = STOP;
          end else if (tick_run) begin
            st_n = sec_tens_inc;
            so_n = sec_ones_inc;
            if (sec_carry) begin
              mt_n   = min_tens_inc;
              mo_n   = min_ones_inc;
              wrap_n = min_roll;
            end
          end
        end
        ADJ: begin
          if (tick_adj) begin
            if (sel) begin
              st_n = sec_tens_inc;
              so_n = sec_ones_inc;
            end else begin
              mt_n = min_tens_inc;
              mo_n = min_ones_inc;
            end
          end
        end
        default: state_n = STOP;
      endcase
    end
  end

  // state, stored digits, running and wrap registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STOP;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      mt_q    <= mt_n;
      mo_q    <= mo_n;
      st_q    <= st_n;
      so_q    <= so_n;
      running <= (state_n == RUN);
      wrap    <= wrap_n;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic blink, blink_n;

  // blink toggles on tick_run only while staying in ADJ
  always_comb begin
    blink_n = 1'b0;
    if (state == ADJ && state_n == ADJ) blink_n = blink ^ tick_run;
  end

  // display registers: blank the selected field from next-cycle values so
  // the outputs stay registered with the same one-clk latency as the digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink    <= 1'b0;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      blink    <= blink_n;
      min_tens <= (blink_n && !sel) ? 4'hF : mt_n;
      min_ones <= (blink_n && !sel) ? 4'hF : mo_n;
      sec_tens <= (blink_n &&  sel) ? 4'hF : st_n;
      sec_ones <= (blink_n &&  sel) ? 4'hF : so_n;
    end
  end
`else
  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed self-checking bench for stopwatch_core
// (default build, MIN_LIMIT = 59).
module tb_stopwatch_core;

  logic       clk;
  logic       rst;
  logic       tick_run, tick_adj, pause_btn, clear_btn, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, wrap;
  logic [15:0] digits;

  int total;
  int bad;
  int wrap_seen;

  stopwatch_core #(.MIN_LIMIT(59)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_run  (tick_run),
    .tick_adj  (tick_adj),
    .pause_btn (pause_btn),
    .clear_btn (clear_btn),
    .adj       (adj),
    .sel       (sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .wrap      (wrap)
  );

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_run = 1'b1; cyc(); tick_run = 1'b0;
      if (wrap) wrap_seen++;
      cyc();
      if (wrap) wrap_seen++;
    end
  endtask

  task automatic adj_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_adj = 1'b1; cyc(); tick_adj = 1'b0;
      if (wrap) wrap_seen++;
      cyc();
    end
  endtask

  initial begin
    total = 0; bad = 0; wrap_seen = 0;
    rst = 1'b0;
    tick_run = 0; tick_adj = 0; pause_btn = 0; clear_btn = 0; adj = 0; sel = 0;
    #12;
    check("reset_digits", digits, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd1 - 16'd1);
    check("reset_wrap", {15'd0, wrap}, 16'h0000);
    @(posedge clk); #1 rst = 1'b1;
    cyc();

    // run 61 seconds from zero
    pulse_pause();
    check("run_after_pause", {15'd0, running}, 16'h0001);
    run_ticks(61);
    check("count_61", digits, 16'h0101);
    check("running_61", {15'd0, running}, 16'h0001);
    check("no_wrap_61", 16'(wrap_seen), 16'h0000);

    // clear, count to 00:10, pause freezes count
    clear_btn = 1'b1; cyc(); clear_btn = 1'b0;
    check("clear_run", digits, 16'h0000);
    check("clear_stops", {15'd0, running}, 16'h0000);
    pulse_pause();
    run_ticks(10);
    check("count_10", digits, 16'h0010);
    pulse_pause();
    check("paused_running", {15'd0, running}, 16'h0000);
    run_ticks(5);
    check("paused_hold", digits, 16'h0010);
    pulse_pause();
    run_ticks(1);
    check("resume_11", digits, 16'h0011);
    check("resume_running", {15'd0, running}, 16'h0001);

    // adjust seconds with rollover, then minutes
    adj = 1'b1; cyc();
    check("adj_running", {15'd0, running}, 16'h0000);
    sel = 1'b1;
    adj_ticks(47);
    check("adj_sec_58", digits, 16'h0058);
    adj_ticks(3);
    check("adj_sec_roll", digits, 16'h0001);
    sel = 1'b0;
    adj_ticks(2);
    check("adj_min_2", digits, 16'h0201);
    run_ticks(2);
    check("adj_ignores_run_tick", digits, 16'h0201);
    adj = 1'b0; cyc();
    check("adj_exit_digits", digits, 16'h0201);
    check("adj_exit_running", {15'd0, running}, 16'h0000);
    run_ticks(2);
    check("stop_ignores_tick", digits, 16'h0201);

    // minutes rollover in ADJ gives no wrap; preload 59:59
    adj = 1'b1; cyc();
    sel = 1'b0;
    adj_ticks(57);
    check("adj_min_59", digits, 16'h5901);
    wrap_seen = 0;
    adj_ticks(1);
    check("adj_min_roll", digits, 16'h0001);
    check("adj_min_no_wrap", 16'(wrap_seen), 16'h0000);
    adj_ticks(59);
    sel = 1'b1;
    adj_ticks(58);
    check("preload_5959", digits, 16'h5959);
    adj = 1'b0; cyc();
    pulse_pause();
    tick_run = 1'b1; cyc(); tick_run = 1'b0;
    check("full_roll", digits, 16'h0000);
    check("wrap_pulse", {15'd0, wrap}, 16'h0001);
    cyc();
    check("wrap_one_clk", {15'd0, wrap}, 16'h0000);

    // clear beats tick in RUN -> STOP
    adj = 1'b1; cyc();
    sel = 1'b0; adj_ticks(3);
    sel = 1'b1; adj_ticks(7);
    adj = 1'b0; cyc();
    pulse_pause();
    check("preload_0307", digits, 16'h0307);
    clear_btn = 1'b1; tick_run = 1'b1; cyc(); clear_btn = 1'b0; tick_run = 1'b0;
    check("clear_tick_digits", digits, 16'h0000);
    check("clear_tick_stop", {15'd0, running}, 16'h0000);
    run_ticks(1);
    check("clear_left_stop", digits, 16'h0000);

    // clear with adj=1 -> ADJ
    adj = 1'b1; cyc();
    sel = 1'b0; adj_ticks(3);
    sel = 1'b1; adj_ticks(7);
    adj = 1'b0; cyc();
    pulse_pause();
    adj = 1'b1; clear_btn = 1'b1; tick_run = 1'b1; cyc(); clear_btn = 1'b0; tick_run = 1'b0;
    check("clear_adj_digits", digits, 16'h0000);
    check("clear_adj_running", {15'd0, running}, 16'h0000);
    adj_ticks(1);
    check("clear_adj_state", digits, 16'h0001);

    // pause beats tick in RUN
    adj = 1'b0; cyc();
    pulse_pause();
    pause_btn = 1'b1; tick_run = 1'b1; cyc(); pause_btn = 1'b0; tick_run = 1'b0;
    check("pause_tick_digits", digits, 16'h0001);
    check("pause_tick_stop", {15'd0, running}, 16'h0000);

    // asynchronous reset mid-count
    pulse_pause();
    run_ticks(1);
    check("pre_rst_count", digits, 16'h0002);
    rst = 1'b0;
    #2;
    check("async_rst_digits", digits, 16'h0000);
    check("async_rst_running", {15'd0, running}, 16'h0000);
    cyc();
    rst = 1'b1;
    run_ticks(2);
    check("post_rst_stop", digits, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
